// File: rtl/piso_tx_sched.sv
// rtl/piso_tx_sched.sv - round-robin scheduler feeding one start/stop framed PISO shifter
module piso_tx_sched #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     data,
    output logic [NREQ-1:0]           gnt,
    output logic                      so,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NREQ)-1:0]   cur_id
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [IDW-1:0]   last, last_n, cur_n;
    logic [NREQ-1:0]  gnt_n;
    logic             so_n, busy_n, done_n;

    logic             win_found;
    logic [IDW-1:0]   win_idx;
    logic [NREQ-1:0]  win_oh;
    logic [WIDTH-1:0] win_data;
    logic [NREQ*WIDTH-1:0] win_sel;
    int               arb_k;

    logic             out_bit;
    logic [WIDTH-1:0] shifted;

    // Scan from the requester after the last winner, wrapping, and take the first set req.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_oh    = '0;
        arb_k     = 0;
        for (int i = 0; i < NREQ; i++) begin
            arb_k = (int'(last) + 1 + i) % NREQ;
            if (!win_found && ((req & (NREQ'(1) << arb_k)) != '0)) begin
                win_found = 1'b1;
                win_idx   = IDW'(arb_k);
                win_oh    = NREQ'(1) << arb_k;
            end
        end
        win_sel  = data >> (int'(win_idx) * WIDTH);
        win_data = win_sel[WIDTH-1:0];
    end

    assign out_bit = (LSB_FIRST != 0) ? shreg[0] : shreg[WIDTH-1];
    assign shifted = (LSB_FIRST != 0) ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};

    // Outputs are computed for the next cycle and registered alongside the state.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = cnt;
        last_n  = last;
        cur_n   = cur_id;
        gnt_n   = '0;
        so_n    = 1'b1;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        case (state)
            IDLE, STOP: begin
                if (win_found) begin
                    state_n = START;
                    shreg_n = win_data;
                    last_n  = win_idx;
                    cur_n   = win_idx;
                    gnt_n   = win_oh;
                    so_n    = 1'b0;
                    busy_n  = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            START: begin
                state_n = SHIFT;
                cnt_n   = '0;
                so_n    = out_bit;
                shreg_n = shifted;
                busy_n  = 1'b1;
            end
            SHIFT: begin
                busy_n = 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    state_n = STOP;
                    done_n  = 1'b1;
                end else begin
                    cnt_n   = cnt + CW'(1);
                    so_n    = out_bit;
                    shreg_n = shifted;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            last   <= IDW'(NREQ - 1);
            cur_id <= '0;
            gnt    <= '0;
            so     <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            shreg  <= shreg_n;
            cnt    <= cnt_n;
            last   <= last_n;
            cur_id <= cur_n;
            gnt    <= gnt_n;
            so     <= so_n;
            busy   <= busy_n;
            done   <= done_n;
        end
    end
endmodule

// File: tb/tb_piso_tx_sched.sv
// tb/tb_piso_tx_sched.sv - randomized frame-level model check of piso_tx_sched
module tb_piso_tx_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;

    logic [NREQ-1:0] gnt_l, gnt_m;
    logic            so_l, so_m, busy_l, busy_m, done_l, done_m;
    logic [1:0]      cur_l, cur_m;

    piso_tx_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LSB_FIRST(1)) dut_lsb (
        .clk(clk), .rst(rst), .req(req), .data(data),
        .gnt(gnt_l), .so(so_l), .busy(busy_l), .done(done_l), .cur_id(cur_l));

    piso_tx_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LSB_FIRST(0)) dut_msb (
        .clk(clk), .rst(rst), .req(req), .data(data),
        .gnt(gnt_m), .so(so_m), .busy(busy_m), .done(done_m), .cur_id(cur_m));

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame model: pos = -1 idle, 0 start bit, 1..WIDTH data bits, WIDTH+1 stop bit.
    int               pos   = -1;
    int               owner = 0;
    int               last  = NREQ - 1;
    logic [WIDTH-1:0] word  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_so(input bit lsb);
        logic [WIDTH-1:0] s;
        if (pos == 0) return 1'b0;
        if (pos >= 1 && pos <= WIDTH) begin
            s = lsb ? (word >> (pos - 1)) : (word >> (WIDTH - pos));
            return s[0];
        end
        return 1'b1;
    endfunction

    task automatic model_edge();
        logic [NREQ*WIDTH-1:0] t;
        bit found;
        int k;
        if (!rst) begin
            pos  = -1;
            last = NREQ - 1;
        end else if (pos == -1 || pos == WIDTH + 1) begin
            found = 0;
            for (int i = 0; i < NREQ; i++) begin
                k = (last + 1 + i) % NREQ;
                if (!found && req[k]) begin
                    found = 1;
                    owner = k;
                    last  = k;
                    t     = data >> (k * WIDTH);
                    word  = t[WIDTH-1:0];
                end
            end
            pos = found ? 0 : -1;
        end else begin
            pos++;
        end
    endtask

    task automatic check_outputs();
        logic [31:0] eg;
        eg = (pos == 0) ? (32'd1 << owner) : 32'd0;
        check("gnt_lsb",  32'(gnt_l),  eg);
        check("gnt_msb",  32'(gnt_m),  eg);
        check("so_lsb",   32'(so_l),   32'(exp_so(1'b1)));
        check("so_msb",   32'(so_m),   32'(exp_so(1'b0)));
        check("busy",     32'(busy_l), 32'(pos >= 0));
        check("done",     32'(done_l), 32'(pos == WIDTH + 1));
        check("busy_msb", 32'(busy_m), 32'(pos >= 0));
        check("done_msb", 32'(done_m), 32'(pos == WIDTH + 1));
        if (pos >= 0) begin
            check("cur_id", 32'(cur_l), 32'(owner));
            check("cur_id_msb", 32'(cur_m), 32'(owner));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic run(input int n, input bit hold);
        repeat (n) begin
            step();
            if (pos == 0 && !hold) req[owner] = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] seq;
        int gq[$];
        int gc[$];
        bit busy_drop;
        int n;

        rst  = 1'b0;
        req  = '0;
        data = '0;
        step();
        step();
        check("rst_so",   32'(so_l),   32'd1);
        check("rst_busy", 32'(busy_l), 32'd0);
        check("rst_done", 32'(done_l), 32'd0);
        check("rst_gnt",  32'(gnt_l),  32'd0);
        check("rst_cur",  32'(cur_l),  32'd0);
        rst = 1'b1;

        // Single LSB-first frame from requester 0.
        data[3:0] = 4'b1011;
        req = 4'b0001;
        seq = '0;
        step();
        check("t1_gnt", 32'(gnt_l), 32'd1);
        seq = {seq[4:0], so_l};
        req = 4'b0000;
        repeat (5) begin
            step();
            seq = {seq[4:0], so_l};
        end
        check("t1_so_seq", 32'(seq), 32'(6'b011011));
        run(3, 1'b0);
        check("t1_idle_so", 32'(so_l), 32'd1);

        // All requesters continuously requesting.
        do_reset();
        data = {4'h8, 4'h4, 4'h2, 4'h1};
        req = 4'b1111;
        busy_drop = 0;
        for (int c = 0; c < 32; c++) begin
            step();
            if (gnt_l != 0) begin
                gq.push_back($clog2(gnt_l));
                gc.push_back(c);
            end
            if (gq.size() > 0 && !busy_l) busy_drop = 1;
        end
        check("t2_ngrants", 32'(gq.size() >= 5), 32'd1);
        if (gq.size() >= 5) begin
            for (int k = 0; k < 5; k++) check("t2_order", 32'(gq[k]), 32'(k % 4));
            for (int k = 1; k < 5; k++) check("t2_gap", 32'(gc[k] - gc[k-1]), 32'd6);
        end
        check("t2_busy_hold", 32'(busy_drop), 32'd0);

        // Pointer wrap after a grant to requester 2.
        do_reset();
        req = 4'b0100;
        step();
        check("t3_first", 32'(gnt_l), 32'h4);
        req = 4'b1010;
        gq.delete();
        for (int c = 0; c < 20; c++) begin
            step();
            check("t3_onehot", 32'($onehot0(gnt_l)), 32'd1);
            if (gnt_l != 0) gq.push_back($clog2(gnt_l));
        end
        check("t3_ngrants", 32'(gq.size()), 32'd3);
        if (gq.size() == 3) begin
            check("t3_g0", 32'(gq[0]), 32'd3);
            check("t3_g1", 32'(gq[1]), 32'd1);
            check("t3_g2", 32'(gq[2]), 32'd3);
        end

        // MSB-first frame from requester 1.
        do_reset();
        data[7:4] = 4'b1000;
        req = 4'b0010;
        step();
        check("t4_gnt", 32'(gnt_m), 32'h2);
        seq = {5'b0, so_m};
        req = 4'b0000;
        repeat (5) begin
            step();
            seq = {seq[4:0], so_m};
        end
        check("t4_so_seq", 32'(seq), 32'(6'b010001));

        // Reset during the third SHIFT cycle.
        do_reset();
        data[3:0] = 4'($urandom);
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        step();
        step();
        rst = 1'b0;
        step();
        check("t5_so",   32'(so_l),   32'd1);
        check("t5_busy", 32'(busy_l), 32'd0);
        check("t5_done", 32'(done_l), 32'd0);
        rst = 1'b1;
        step();
        check("t5_nodone", 32'(done_l), 32'd0);
        req = 4'b0011;
        step();
        check("t5_gnt", 32'(gnt_l), 32'h1);
        req[0] = 1'b0;
        run(14, 1'b0);

        // Request raised mid-frame waits for the edge ending STOP.
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0000;
        step();
        step();
        req = 4'b0100;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            n++;
            if (gnt_l != 0) break;
        end
        check("t6_gnt_at", 32'(n), 32'd4);
        check("t6_gnt", 32'(gnt_l), 32'h4);
        req = 4'b0000;
        run(8, 1'b0);

        // Randomized traffic with occasional resets and post-capture data churn.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) != 0);
            step();
            check("rand_onehot", 32'($onehot0(gnt_l)), 32'd1);
            if (pos == 0) begin
                req[owner] = ($urandom_range(0, 3) == 0);
                data[owner*WIDTH +: WIDTH] = 4'($urandom);
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i]) begin
                    data[i*WIDTH +: WIDTH] = 4'($urandom);
                    if ($urandom_range(0, 4) == 0) req[i] = 1'b1;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
